raw_hazard_unit: RTL and testbench

Parametrised read-after-write hazard unit for the five-stage pipeline, successor to the single-source WB->ID forwarding selector. It tracks the destination register of every instruction in EX, MEM and WB in an internal scoreboard, selects the forwarding source for each ID-stage read port with youngest-writer priority, and raises a load-use stall when the needed value is not yet available. It sits beside the ID stage, driving the operand muxes and the IF/ID freeze and EX-bubble controls, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/raw_hazard_unit.sv | 86 ++++++++
 tb/tb_raw_hazard_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/raw_hazard_unit.sv
// RAW hazard unit: EX/MEM/WB destination scoreboard, per-port forwarding select, load-use stall.
// fwd_sel/stall are combinational from scoreboard + ID inputs; hold freezes slots and the stall counter.
module raw_hazard_unit #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_id,
  input  logic [NUM_RD-1:0]        rd_used_id,
  input  logic                     issue_valid_id,
  input  logic                     wr_en_id,
  input  logic [ADDR_W-1:0]        wr_addr_id,
  input  logic                     is_load_id,
  input  logic                     flush_id,
  input  logic                     hold,
  output logic [2*NUM_RD-1:0]      fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  logic              r_ex_vld, r_ex_wen, r_ex_ld;
  logic [ADDR_W-1:0] r_ex_addr;
  logic              r_mem_vld, r_mem_wen, r_mem_ld;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_wb_vld, r_wb_wen;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [NUM_RD-1:0] w_hazard;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic              w_live, w_ex_hit, w_mem_hit, w_wb_hit;

    assign w_addr    = rd_addr_id[k*ADDR_W +: ADDR_W];
    assign w_live    = rd_used_id[k] && (w_addr != '0);
    assign w_ex_hit  = w_live && r_ex_vld  && r_ex_wen  && (r_ex_addr  == w_addr);
    assign w_mem_hit = w_live && r_mem_vld && r_mem_wen && (r_mem_addr == w_addr);
    assign w_wb_hit  = w_live && r_wb_vld  && r_wb_wen  && (r_wb_addr  == w_addr);

    // Youngest writer wins; a load found in WB already has its data, so it forwards normally.
    assign fwd_sel[2*k +: 2] = w_ex_hit  ? 2'b01 :
                               w_mem_hit ? 2'b10 :
                               w_wb_hit  ? 2'b11 : 2'b00;
    assign w_hazard[k] = (w_ex_hit && r_ex_ld) || (!w_ex_hit && w_mem_hit && r_mem_ld);
  end

  assign stall     = issue_valid_id && !flush_id && (|w_hazard);
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_vld    <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_addr   <= '0;
      r_mem_vld   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_ld    <= 1'b0;
      r_mem_addr  <= '0;
      r_wb_vld    <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_wb_addr   <= '0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      // A stalled or flushed ID instruction is replaced by a bubble in EX.
      r_ex_vld   <= issue_valid_id && !stall && !flush_id;
      r_ex_wen   <= wr_en_id;
      r_ex_ld    <= is_load_id;
      r_ex_addr  <= wr_addr_id;
      r_mem_vld  <= r_ex_vld;
      r_mem_wen  <= r_ex_wen;
      r_mem_ld   <= r_ex_ld;
      r_mem_addr <= r_ex_addr;
      r_wb_vld   <= r_mem_vld;
      r_wb_wen   <= r_mem_wen;
      r_wb_addr  <= r_mem_addr;
      if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_raw_hazard_unit.sv
// Directed bench for raw_hazard_unit: a default instance plus a 2-bit-counter instance sharing stimulus.
module tb_raw_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr_id = '0;
  logic [1:0]  rd_used_id = '0;
  logic        issue_valid_id = 1'b0;
  logic        wr_en_id = 1'b0;
  logic [4:0]  wr_addr_id = '0;
  logic        is_load_id = 1'b0;
  logic        flush_id = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  fwd_sel, fwd_sel_s;
  logic        stall, stall_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  raw_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_id(rd_addr_id), .rd_used_id(rd_used_id),
    .issue_valid_id(issue_valid_id), .wr_en_id(wr_en_id), .wr_addr_id(wr_addr_id),
    .is_load_id(is_load_id), .flush_id(flush_id), .hold(hold),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  raw_hazard_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rd_addr_id(rd_addr_id), .rd_used_id(rd_used_id),
    .issue_valid_id(issue_valid_id), .wr_en_id(wr_en_id), .wr_addr_id(wr_addr_id),
    .is_load_id(is_load_id), .flush_id(flush_id), .hold(hold),
    .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic wen, input logic [4:0] wa, input logic ld,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
    issue_valid_id = v;
    wr_en_id       = wen;
    wr_addr_id     = wa;
    is_load_id     = ld;
    rd_addr_id     = {a1, a0};
    rd_used_id     = used;
    flush_id       = 1'b0;
    hold           = 1'b0;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), 2'($urandom));
      tick();
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_id(0, 0, 0, 0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 2'b11);
      #1;
      checks++;
      if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_drain fwd_sel=%b stall=%b exp=0000/0", fwd_sel, stall);
      end
      tick();
    end
    // Reset while a load-use stall is pending
    set_id(1, 1, 5'd4, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd4, 0, 2'b01);
    #1;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL reset_pre_stall got=%b exp=1", stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_mid_stall got=%b exp=0", stall); end
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'b01; exp_sel[1] = 2'b10; exp_sel[2] = 2'b11; exp_sel[3] = 2'b00;
    do_reset();
    set_id(1, 1, 5'd3, 0, 0, 0, 2'b00);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 0, 0, 5'd3, 5'd0, 2'b01);
      #1;
      checks++;
      if (fwd_sel !== {2'b00, exp_sel[i]} || stall !== 1'b0) begin
        failures++;
        $display("FAIL alu_dist%0d fwd_sel=%b stall=%b exp=00%b/0", i + 1, fwd_sel, stall, exp_sel[i]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 5'd5, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd0, 5'd5, 2'b10);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL load_use_stall%0d got=%b exp=1", i, stall); end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'b11) begin
      failures++;
      $display("FAIL load_use_release stall=%b fwd1=%b exp=0/11", stall, fwd_sel[3:2]);
    end
    checks++;
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL load_use_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_priority_r0();
    do_reset();
    set_id(1, 1, 5'd7, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 1, 5'd7, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd7, 5'd7, 2'b11);
    #1;
    checks++;
    if (fwd_sel !== 4'b0101) begin failures++; $display("FAIL prio_youngest got=%b exp=0101", fwd_sel); end
    tick();
    set_id(1, 1, 5'd0, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd0, 5'd0, 2'b11);
    #1;
    checks++;
    if (fwd_sel[1:0] !== 2'b00 || stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_write fwd0=%b stall=%b exp=00/0", fwd_sel[1:0], stall);
    end
    // Unused port pointing at a pending load never stalls
    tick();
    set_id(1, 1, 5'd8, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd8, 5'd8, 2'b00);
    #1;
    checks++;
    if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL unused_port fwd_sel=%b stall=%b exp=0000/0", fwd_sel, stall);
    end
  endtask

  task automatic test_hold_flush();
    do_reset();
    set_id(1, 1, 5'd5, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd5, 0, 2'b01);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stall !== 1'b1 || stall_cnt !== 16'd0) begin
        failures++;
        $display("FAIL hold%0d stall=%b cnt=%0d exp=1/0", i, stall, stall_cnt);
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL hold_resume stall=%b cnt=%0d exp=1/1", stall, stall_cnt);
    end
    // Flush against a hazard: no stall, and the killed writer of r9 never enters EX
    do_reset();
    set_id(1, 1, 5'd6, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 1, 5'd9, 0, 5'd6, 0, 2'b01);
    flush_id = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    set_id(1, 0, 0, 0, 5'd6, 5'd9, 2'b11);
    #1;
    checks++;
    if (fwd_sel[3:2] !== 2'b00 || stall !== 1'b1) begin
      failures++;
      $display("FAIL flush_bubble fwd1=%b stall=%b exp=00/1", fwd_sel[3:2], stall);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_id(1, 1, 5'd5, 1, 0, 0, 2'b00);
      tick();
      set_id(1, 0, 0, 0, 5'd5, 0, 2'b01);
      tick();
      tick();
      tick();
    end
    checks++;
    if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd4) begin
      failures++;
      $display("FAIL sat_four cnt2=%0d cnt16=%0d exp=3/4", stall_cnt_s, stall_cnt);
    end
    set_id(1, 1, 5'd5, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 5'd5, 0, 2'b01);
    tick();
    tick();
    checks++;
    if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL sat_five cnt2=%0d cnt16=%0d exp=3/5", stall_cnt_s, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_r0();
    test_hold_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
